mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 46 ++++
 rtl/load_align.sv | 29 ++
 rtl/mem_access_unit.sv | 112 +++++++++++
 tb/tb_mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: operation encodings, FSM states,
// and the lane helpers used by the control decoder.
package mem_pkg;

    typedef enum logic [2:0] {
        MEM_LW  = 3'b000,
        MEM_LH  = 3'b001,
        MEM_LHU = 3'b010,
        MEM_LB  = 3'b011,
        MEM_LBU = 3'b100,
        MEM_SW  = 3'b101,
        MEM_SH  = 3'b110,
        MEM_SB  = 3'b111
    } mem_op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MERGE_WR = 1'b1
    } state_e;

    localparam logic [7:0] MISALIGN_CNT_MAX = 8'hFF;

    // Word ops need addr[1:0]==0; halfword ops need addr[0]==0; bytes are always aligned.
    function automatic logic is_misaligned(mem_op_e op, logic [1:0] addr_lo);
        logic mis;
        case (op)
            MEM_LW, MEM_SW:          mis = (addr_lo != 2'b00);
            MEM_LH, MEM_LHU, MEM_SH: mis = addr_lo[0];
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] merge_lane(mem_op_e op, logic [1:0] addr_lo,
                                               logic [31:0] old_word, logic [31:0] wdata);
        logic [31:0] merged;
        merged = old_word;
        if (op == MEM_SB) begin
            merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        end else begin
            merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
        end
        return merged;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane selection and sign/zero extension for a little-endian word memory.
module load_align
    import mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] dm_rdata,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = dm_rdata[{addr_lo, 3'b000} +: 8];
        half_sel = dm_rdata[{addr_lo[1], 4'b0000} +: 16];
        // NOTE: default assignment first so no path through the case infers a latch.
        rdata = '0;
        case (mem_op_e'(op))
            MEM_LW:  rdata = dm_rdata;
            MEM_LH:  rdata = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: rdata = {16'h0000, half_sel};
            MEM_LB:  rdata = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: rdata = {24'h000000, byte_sel};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: single-cycle loads and word stores, two-cycle read-merge-write
// for sub-word stores, misalignment suppression with a saturating event counter.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic [7:0]        misalign_cnt,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic              dm_we,
    input  logic [31:0]       dm_rdata
);

    state_e            state_q, state_d;
    logic [31:0]       merge_q, merge_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        cnt_q, cnt_d;

    mem_op_e     op_v;
    logic [31:0] load_rdata;
    logic        stall_w, dm_we_w, misalign_w;
    logic [31:0] rdata_w;

    assign op_v = mem_op_e'(op);

    load_align u_load_align (
        .op       (op),
        .addr_lo  (addr[1:0]),
        .dm_rdata (dm_rdata),
        .rdata    (load_rdata)
    );

    always_comb begin
        state_d    = state_q;
        merge_d    = merge_q;
        waddr_d    = waddr_q;
        cnt_d      = cnt_q;
        dm_addr    = addr;
        dm_wdata   = wdata;
        dm_we_w    = 1'b0;
        stall_w    = 1'b0;
        rdata_w    = '0;
        misalign_w = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (is_misaligned(op_v, addr[1:0])) begin
                        misalign_w = 1'b1;
                        if (cnt_q != MISALIGN_CNT_MAX) begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else begin
                        case (op_v)
                            MEM_SW: dm_we_w = 1'b1;
                            MEM_SH, MEM_SB: begin
                                // Capture the merged word now while dm_rdata shows the old contents.
                                stall_w = 1'b1;
                                merge_d = merge_lane(op_v, addr[1:0], dm_rdata, wdata);
                                waddr_d = addr;
                                state_d = ST_MERGE_WR;
                            end
                            default: rdata_w = load_rdata;
                        endcase
                    end
                end
            end
            ST_MERGE_WR: begin
                dm_addr  = waddr_q;
                dm_wdata = merge_q;
                dm_we_w  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset gates every control output so nothing reaches memory while reset_n is low.
    assign dm_we        = reset_n & dm_we_w;
    assign stall        = reset_n & stall_w;
    assign misalign     = reset_n & misalign_w;
    assign rdata        = reset_n ? rdata_w : 32'h0000_0000;
    assign misalign_cnt = cnt_q;

    // NOTE: only the small merge/address registers live here and are reset; word
    // storage stays in the external data memory, which is never cleared by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            merge_q <= '0;
            waddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            merge_q <= merge_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random traffic
// against a byte-addressed reference memory model.
module tb_mem_access_unit;

    localparam int ADDR_W = 32;
    localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                           OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              stall;
    logic [31:0]       rdata;
    logic              misalign;
    logic [7:0]        misalign_cnt;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_we;
    logic [31:0]       dm_rdata;

    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    logic [7:0]  ref_bytes [0:255];
    logic [31:0] init_w [0:63];
    int          ref_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req          (req),
        .op           (op),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .rdata        (rdata),
        .misalign     (misalign),
        .misalign_cnt (misalign_cnt),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_we        (dm_we),
        .dm_rdata     (dm_rdata)
    );

    // Word-wide data memory: asynchronous read, write on the clock edge.
    assign dm_rdata = mem[dm_addr[7:2]];
    always @(posedge clock) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (dm_we) mem[dm_addr[7:2]] <= dm_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_mis(input logic [2:0] o, input logic [31:0] a);
        if (o == OP_LW || o == OP_SW) return a[1:0] != 2'b00;
        if (o == OP_LH || o == OP_LHU || o == OP_SH) return a[0];
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [7:0] w;
        w = {a[7:2], 2'b00};
        return {ref_bytes[w + 8'd3], ref_bytes[w + 8'd2], ref_bytes[w + 8'd1], ref_bytes[w]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] a);
        logic [7:0]  a8;
        logic [7:0]  b;
        logic [15:0] h;
        a8 = a[7:0];
        b  = ref_bytes[a8];
        h  = {ref_bytes[a8 + 8'd1], ref_bytes[a8]};
        case (o)
            OP_LW:   return ref_word(a);
            OP_LH:   return 32'($signed(h));
            OP_LHU:  return {16'h0000, h};
            OP_LB:   return 32'($signed(b));
            OP_LBU:  return {24'h000000, b};
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd);
        int nbytes;
        nbytes = (o == OP_SW) ? 4 : (o == OP_SH) ? 2 : 1;
        for (int i = 0; i < nbytes; i++) ref_bytes[a[7:0] + 8'(i)] = wd[8*i +: 8];
    endtask

    // Issue one request and follow it to completion, checking every cycle against the model.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] obs_rd, output logic [31:0] obs_wr, output int cycles);
        logic m;
        int   n;
        obs_rd = '0;
        obs_wr = '0;
        cycles = 0;
        @(negedge clock);
        check("misalign_cnt", 32'(misalign_cnt), ref_cnt);
        req = 1'b1; op = o; addr = a; wdata = wd;
        #1;
        m = ref_mis(o, a);
        check("misalign", 32'(misalign), 32'(m));
        if (m) begin
            check("mis_stall", 32'(stall), 32'd0);
            check("mis_dm_we", 32'(dm_we), 32'd0);
            check("mis_rdata", rdata, 32'd0);
            if (ref_cnt < 255) ref_cnt++;
        end else if (o <= OP_LBU) begin
            check("ld_stall", 32'(stall), 32'd0);
            check("ld_dm_we", 32'(dm_we), 32'd0);
            check("ld_dm_addr", dm_addr, a);
            check("ld_rdata", rdata, ref_load(o, a));
            obs_rd = rdata;
        end else if (o == OP_SW) begin
            check("sw_stall", 32'(stall), 32'd0);
            check("sw_dm_we", 32'(dm_we), 32'd1);
            check("sw_dm_addr", dm_addr, a);
            check("sw_dm_wdata", dm_wdata, wd);
            obs_wr = dm_wdata;
            ref_store(o, a, wd);
        end else begin
            check("sub_stall", 32'(stall), 32'd1);
            check("sub_dm_we", 32'(dm_we), 32'd0);
            check("sub_rdata", rdata, 32'd0);
            ref_store(o, a, wd);
            @(posedge clock);
            n = 0;
            do begin
                @(negedge clock);
                req = 1'b1; op = 3'($urandom); addr = $urandom; wdata = $urandom;
                #1;
                n++;
            end while (dm_we !== 1'b1 && n < 4);
            cycles = n;
            check("mw_dm_we", 32'(dm_we), 32'd1);
            check("mw_stall", 32'(stall), 32'd0);
            check("mw_rdata", rdata, 32'd0);
            check("mw_misalign", 32'(misalign), 32'd0);
            check("mw_dm_addr", dm_addr, a);
            check("mw_dm_wdata", dm_wdata, ref_word(a));
            obs_wr = dm_wdata;
        end
        @(posedge clock);
        cycles += 1;
        #1 req = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, wr, w, sh_wd, sb_wd;
        int          cyc, cyc_a, cyc_b;
        logic [2:0]  mis_ops [0:4];

        mis_ops = '{OP_LW, OP_LH, OP_LHU, OP_SW, OP_SH};
        reset_n = 1'b0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        req = 1'b1; op = OP_SW; addr = 32'h20; wdata = 32'hFFFF_FFFF;
        #1;
        check("rst_dm_we", 32'(dm_we), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_cnt", 32'(misalign_cnt), 32'd0);

        for (int i = 0; i < 64; i++) begin
            w = (i == 4) ? 32'h8899_AABB : $urandom;
            init_w[i] = w;
            for (int k = 0; k < 4; k++) ref_bytes[i*4 + k] = w[8*k +: 8];
            @(negedge clock);
            pre_we = 1'b1; pre_idx = 6'(i); pre_data = w;
        end
        @(negedge clock);
        pre_we = 1'b0;
        #1 check("rst_hold_dm_we", 32'(dm_we), 32'd0);
        req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        // Sub-word loads from 0x8899AABB
        issue(OP_LB, 32'h11, 32'h0, rd, wr, cyc);  check("lb_11", rd, 32'hFFFF_FFAA);
        issue(OP_LBU, 32'h11, 32'h0, rd, wr, cyc); check("lbu_11", rd, 32'h0000_00AA);
        issue(OP_LH, 32'h12, 32'h0, rd, wr, cyc);  check("lh_12", rd, 32'hFFFF_8899);
        issue(OP_LHU, 32'h12, 32'h0, rd, wr, cyc); check("lhu_12", rd, 32'h0000_8899);

        // Byte store merge
        issue(OP_SB, 32'h13, 32'h1234_5677, rd, wr, cyc);
        check("sb_merged", wr, 32'h7799_AABB);
        check("sb_cycles", 32'(cyc), 32'd2);
        issue(OP_LW, 32'h10, 32'h0, rd, wr, cyc);  check("lw_10", rd, 32'h7799_AABB);

        // Word store
        issue(OP_SW, 32'h20, 32'hDEAD_BEEF, rd, wr, cyc);
        check("sw_cycles", 32'(cyc), 32'd1);
        issue(OP_LW, 32'h20, 32'h0, rd, wr, cyc);  check("lw_20", rd, 32'hDEAD_BEEF);

        // Misalignment and counter saturation
        issue(OP_LW, 32'h22, 32'h0, rd, wr, cyc);
        issue(OP_SH, 32'h21, $urandom, rd, wr, cyc);
        issue(OP_SW, 32'h23, $urandom, rd, wr, cyc);
        @(negedge clock);
        check("cnt_3", 32'(misalign_cnt), 32'd3);
        for (int i = 0; i < 260; i++) begin
            issue(mis_ops[$urandom_range(0, 4)], {24'h0, 7'($urandom), 1'b1}, $urandom, rd, wr, cyc);
        end
        @(negedge clock);
        check("cnt_sat", 32'(misalign_cnt), 32'd255);

        // Reset during MERGE_WR aborts the write
        @(negedge clock);
        req = 1'b1; op = OP_SH; addr = 32'h30; wdata = $urandom;
        #1 check("rm_stall", 32'(stall), 32'd1);
        @(posedge clock);
        #1 req = 1'b0;
        check("rm_pending_we", 32'(dm_we), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rm_dm_we", 32'(dm_we), 32'd0);
        check("rm_stall0", 32'(stall), 32'd0);
        check("rm_misalign", 32'(misalign), 32'd0);
        check("rm_rdata", rdata, 32'd0);
        check("rm_cnt", 32'(misalign_cnt), 32'd0);
        @(posedge clock);
        #1 check("rm_dm_we_edge", 32'(dm_we), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        ref_cnt = 0;
        issue(OP_LW, 32'h30, 32'h0, rd, wr, cyc);
        check("rm_mem_30", rd, init_w[12]);

        // Back-to-back sub-word stores
        sh_wd = $urandom; sb_wd = $urandom;
        issue(OP_SH, 32'h40, sh_wd, rd, wr, cyc_a);
        issue(OP_SB, 32'h41, sb_wd, rd, wr, cyc_b);
        check("b2b_cycles", 32'(cyc_a + cyc_b), 32'd4);
        issue(OP_LW, 32'h40, 32'h0, rd, wr, cyc);
        check("b2b_word", rd, {init_w[16][31:16], sb_wd[7:0], sh_wd[7:0]});

        // Random traffic against the byte model
        for (int i = 0; i < 200; i++) begin
            issue(3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom, rd, wr, cyc);
        end
        @(negedge clock);
        check("final_cnt", 32'(misalign_cnt), ref_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
